// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_hazard_ctrl_pkg
// Brief    : Shared state encoding and sizing helper for the hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_INIT     = 2'd0,
      ST_RUN      = 2'd1,
      ST_MDU_WAIT = 2'd2
   } ctrl_state_t;

   // Wait-counter width; a disabled timeout (0) still needs a 1-bit counter.
   function automatic int cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// ============================================================================
// Module   : hazard_detect
// Brief    : Load-use comparator between the load in E and the sources in D.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect (
   input  logic [4:0] rs1D,
   input  logic [4:0] rs2D,
   input  logic       use_rs1D,
   input  logic       use_rs2D,
   input  logic [4:0] rdE,
   input  logic       MemReadE,
   output logic       lu
);

   logic w_match1;
   logic w_match2;

   assign w_match1 = use_rs1D && (rs1D == rdE);
   assign w_match2 = use_rs2D && (rs2D == rdE);
   // x0 is hard-wired zero, so a load targeting it never creates a dependency.
   assign lu       = MemReadE && (rdE != 5'd0) && (w_match1 || w_match2);

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall/flush sequencing for load-use, EX redirect and MDU waits.
//            Optional macro HAZARD_PERF_EN adds three 32-bit event counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MDU_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs1D,
   input  logic [4:0]  rs2D,
   input  logic        use_rs1D,
   input  logic        use_rs2D,
   input  logic [4:0]  rdE,
   input  logic        MemReadE,
   input  logic        redirectE,
   input  logic        mdu_startE,
   input  logic        mdu_done,
   output logic        stallF,
   output logic        stallD,
   output logic        stallE,
   output logic        flushD,
   output logic        flushE,
   output logic        flushM,
   output logic        mdu_busy,
   output logic        mdu_timeout
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] lu_stall_cnt,
   output logic [31:0] mdu_stall_cnt,
   output logic [31:0] redirect_cnt
`endif
);

   localparam int                 c_CNT_W    = cnt_width(MDU_TIMEOUT);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MDU_TIMEOUT - 1);

   ctrl_state_t        r_state;
   ctrl_state_t        w_state_next;
   logic [c_CNT_W-1:0] r_cnt;
   logic [c_CNT_W-1:0] w_cnt_next;
   logic               w_lu;

   hazard_detect u_hazard_detect (
      .rs1D     (rs1D),
      .rs2D     (rs2D),
      .use_rs1D (use_rs1D),
      .use_rs2D (use_rs2D),
      .rdE      (rdE),
      .MemReadE (MemReadE),
      .lu       (w_lu)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      stallF       = 1'b0;
      stallD       = 1'b0;
      stallE       = 1'b0;
      flushD       = 1'b0;
      flushE       = 1'b0;
      flushM       = 1'b0;
      mdu_busy     = 1'b0;
      mdu_timeout  = 1'b0;

      case (r_state)
         ST_INIT: begin
            stallF       = 1'b1;
            flushD       = 1'b1;
            flushE       = 1'b1;
            flushM       = 1'b1;
            w_state_next = ST_RUN;
         end
         ST_RUN: begin
            if (redirectE) begin
               flushD = 1'b1;
               flushE = 1'b1;
            end else begin
               if (w_lu) begin
                  stallF = 1'b1;
                  stallD = 1'b1;
                  flushE = 1'b1;
               end
               if (mdu_startE) begin
                  w_state_next = ST_MDU_WAIT;
                  w_cnt_next   = '0;
               end
            end
         end
         ST_MDU_WAIT: begin
            mdu_busy = 1'b1;
            // Done and timeout both release in the same cycle; EX/MEM captures the result.
            if (mdu_done) begin
               w_state_next = ST_RUN;
            end else if ((MDU_TIMEOUT != 0) && (r_cnt == c_CNT_LAST)) begin
               mdu_timeout  = 1'b1;
               w_state_next = ST_RUN;
            end else begin
               stallF     = 1'b1;
               stallD     = 1'b1;
               stallE     = 1'b1;
               flushM     = 1'b1;
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_next = ST_INIT;
         end
      endcase

      // Reset forces the INIT output pattern regardless of the current state.
      if (rst) begin
         stallF      = 1'b1;
         stallD      = 1'b0;
         stallE      = 1'b0;
         flushD      = 1'b1;
         flushE      = 1'b1;
         flushM      = 1'b1;
         mdu_busy    = 1'b0;
         mdu_timeout = 1'b0;
      end
   end

`ifdef HAZARD_PERF_EN
   logic w_lu_applied;
   logic w_redir_applied;
   logic w_wait_cycle;

   assign w_redir_applied = (r_state == ST_RUN) && redirectE;
   assign w_lu_applied    = (r_state == ST_RUN) && !redirectE && w_lu;
   assign w_wait_cycle    = (r_state == ST_MDU_WAIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         lu_stall_cnt  <= '0;
         mdu_stall_cnt <= '0;
         redirect_cnt  <= '0;
      end else begin
         if (w_lu_applied)    lu_stall_cnt  <= lu_stall_cnt + 32'd1;
         if (w_wait_cycle)    mdu_stall_cnt <= mdu_stall_cnt + 32'd1;
         if (w_redir_applied) redirect_cnt  <= redirect_cnt + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Scoreboard bench for pipe_hazard_ctrl (directed plus random).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

   localparam int TO = 8;

   typedef struct {
      logic [7:0]  outs;
      logic [31:0] c_lu;
      logic [31:0] c_mdu;
      logic [31:0] c_rd;
      bit          cnt_ok;
      int          phase;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] rs1D = '0, rs2D = '0, rdE = '0;
   logic       use_rs1D = 1'b0, use_rs2D = 1'b0, MemReadE = 1'b0;
   logic       redirectE = 1'b0, mdu_startE = 1'b0, mdu_done = 1'b0;
   logic       stallF, stallD, stallE, flushD, flushE, flushM, mdu_busy, mdu_timeout;
   logic [31:0] lu_stall_cnt, mdu_stall_cnt, redirect_cnt;

   pipe_hazard_ctrl #(.MDU_TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .rs1D        (rs1D),
      .rs2D        (rs2D),
      .use_rs1D    (use_rs1D),
      .use_rs2D    (use_rs2D),
      .rdE         (rdE),
      .MemReadE    (MemReadE),
      .redirectE   (redirectE),
      .mdu_startE  (mdu_startE),
      .mdu_done    (mdu_done),
      .stallF      (stallF),
      .stallD      (stallD),
      .stallE      (stallE),
      .flushD      (flushD),
      .flushE      (flushE),
      .flushM      (flushM),
      .mdu_busy    (mdu_busy),
      .mdu_timeout (mdu_timeout)
`ifdef HAZARD_PERF_EN
      ,
      .lu_stall_cnt  (lu_stall_cnt),
      .mdu_stall_cnt (mdu_stall_cnt),
      .redirect_cnt  (redirect_cnt)
`endif
   );

`ifndef HAZARD_PERF_EN
   assign lu_stall_cnt  = '0;
   assign mdu_stall_cnt = '0;
   assign redirect_cnt  = '0;
`endif

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q[$];

   // Reference model: mode 0=init, 1=run, 2=waiting for MDU.
   int          m_mode   = 0;
   int          m_waited = 0;
   logic [31:0] m_lu = '0, m_mdu = '0, m_rd = '0;
   bit          m_cnt_ok = 1'b0;

   task automatic step(input bit r, input logic [4:0] a, input logic [4:0] b,
                       input bit ua, input bit ub, input logic [4:0] d, input bit mr,
                       input bit rd, input bit st, input bit dn, input int ph);
      bit   sF, sD, sE, fD, fE, fM, busy, tmo, hz;
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; rs1D = a; rs2D = b; use_rs1D = ua; use_rs2D = ub; rdE = d;
      MemReadE = mr; redirectE = rd; mdu_startE = st; mdu_done = dn;
      {sF, sD, sE, fD, fE, fM, busy, tmo} = '0;
      e.c_lu = m_lu; e.c_mdu = m_mdu; e.c_rd = m_rd; e.cnt_ok = m_cnt_ok; e.phase = ph;
      hz = mr && (d != 0) && ((ua && a == d) || (ub && b == d));
      if (r || m_mode == 0) begin
         sF = 1; fD = 1; fE = 1; fM = 1;
      end
      if (r) begin
         m_mode = 0; m_waited = 0;
         m_lu = 0; m_mdu = 0; m_rd = 0; m_cnt_ok = 1'b1;
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (rd) begin
            fD = 1; fE = 1; m_rd++;
         end else begin
            if (hz) begin
               sF = 1; sD = 1; fE = 1; m_lu++;
            end
            if (st) begin
               m_mode = 2; m_waited = 0;
            end
         end
      end else begin
         busy = 1; m_mdu++;
         if (dn) m_mode = 1;
         else if (TO != 0 && m_waited + 1 == TO) begin
            tmo = 1; m_mode = 1;
         end else begin
            sF = 1; sD = 1; sE = 1; fM = 1; m_waited++;
         end
      end
      e.outs = {sF, sD, sE, fD, fE, fM, busy, tmo};
      q.push_back(e);
   endtask

   task automatic idle(input int ph);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ph);
   endtask

   initial begin : monitor
      exp_t        e;
      logic [7:0]  act;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e   = q.pop_front();
            act = {stallF, stallD, stallE, flushD, flushE, flushM, mdu_busy, mdu_timeout};
            n_cmp++;
            if (act !== e.outs) begin
               n_bad++;
               $display("FAIL outputs phase=%0d t=%0t got=%b want=%b (sF sD sE fD fE fM busy tmo)",
                        e.phase, $time, act, e.outs);
            end
`ifdef HAZARD_PERF_EN
            if (e.cnt_ok) begin
               n_cmp++;
               if ({lu_stall_cnt, mdu_stall_cnt, redirect_cnt} !== {e.c_lu, e.c_mdu, e.c_rd}) begin
                  n_bad++;
                  $display("FAIL perf_counters phase=%0d got lu=%0d mdu=%0d rd=%0d want lu=%0d mdu=%0d rd=%0d",
                           e.phase, lu_stall_cnt, mdu_stall_cnt, redirect_cnt, e.c_lu, e.c_mdu, e.c_rd);
               end
            end
`endif
         end
      end
   end

   initial begin : stimulus
      bit rr, rd, st;
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(2); idle(2); idle(2);
      step(0, 0, 5, 0, 1, 5, 1, 0, 0, 0, 3); idle(3);
      step(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 4); idle(4);
      step(0, 7, 0, 1, 0, 7, 1, 1, 0, 0, 5); idle(5);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6);
      for (int i = 0; i < 3; i++) idle(6);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6); idle(6);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7);
      for (int i = 0; i < 10; i++) idle(7);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8);
      idle(8); idle(8); idle(8);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8);
      idle(8); idle(8); idle(8);
      step(0, 3, 3, 1, 1, 3, 1, 0, 1, 0, 9);
      idle(9); idle(9); step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9); idle(9);
      for (int i = 0; i < 3000; i++) begin
         rr = ($urandom_range(0, 199) == 0);
         rd = ($urandom_range(0, 7) == 0);
         st = !rd && ($urandom_range(0, 7) == 0);
         step(rr, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              rd, st, ($urandom_range(0, 5) == 0), 10);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain got=%0d pending want=0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
